// File: rtl/button_scan.sv
// rtl/button_scan.sv - pushbutton/switch synchroniser, tick-based debouncer and press/release/repeat event generator
module button_scan #(
  parameter int PRESCALE_BITS  = 16,
  parameter int STABLE_SAMPLES = 4,
  parameter int REPEAT_DELAY   = 32,
  parameter int REPEAT_RATE    = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_btn_in,
  input  logic [7:0] i_sw_in,
  output logic [3:0] o_btn_level,
  output logic [3:0] o_btn_press,
  output logic [3:0] o_btn_release,
  output logic [3:0] o_btn_repeat,
  output logic [7:0] o_sw_level,
  output logic [7:0] o_sw_change,
  output logic       o_tick
);

  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1) + 1;
  localparam logic [3:0]        CNT_LAST    = 4'(STABLE_SAMPLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_DELAY  = HOLD_W'(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_RATE);

  // Bits [3:0] are the buttons, bits [11:4] the switches.
  logic [11:0]                  r_sync1, r_sync2;
  logic [PRESCALE_BITS-1:0]     r_presc;
  logic [11:0][3:0]             r_cnt;
  logic [11:0]                  r_level, r_rise, r_fall;
  logic [3:0][HOLD_W-1:0]       r_hold;
  logic [3:0]                   r_repeat;

  logic                         w_tick;
  logic [11:0][3:0]             w_cnt_nxt;
  logic [11:0]                  w_level_nxt, w_rise, w_fall;
  logic [3:0][HOLD_W-1:0]       w_hold_nxt;
  logic [3:0]                   w_repeat;
  logic [HOLD_W-1:0]            w_inc;

  assign w_tick = &r_presc;

  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_rise      = '0;
    w_fall      = '0;
    if (w_tick) begin
      for (int i = 0; i < 12; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          w_cnt_nxt[i] = '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          w_level_nxt[i] = ~r_level[i];
          w_cnt_nxt[i]   = '0;
          w_rise[i]      = ~r_level[i];
          w_fall[i]      = r_level[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + 4'd1;
        end
      end
    end
  end

  // Hold counter idles at zero while released; a release tick clears it and eats any due repeat.
  always_comb begin
    w_hold_nxt = r_hold;
    w_repeat   = '0;
    w_inc      = '0;
    for (int b = 0; b < 4; b++) begin
      if (!r_level[b] || w_fall[b]) begin
        w_hold_nxt[b] = '0;
      end else if (w_tick) begin
        w_inc = r_hold[b] + HOLD_W'(1);
        if (w_inc == HOLD_DELAY) begin
          w_repeat[b]   = 1'b1;
          w_hold_nxt[b] = HOLD_RELOAD;
        end else begin
          w_hold_nxt[b] = w_inc;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_presc  <= '0;
      r_cnt    <= '0;
      r_level  <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
      r_hold   <= '0;
      r_repeat <= '0;
    end else begin
      r_sync1  <= {i_sw_in, i_btn_in};
      r_sync2  <= r_sync1;
      r_presc  <= r_presc + PRESCALE_BITS'(1);
      r_cnt    <= w_cnt_nxt;
      r_level  <= w_level_nxt;
      r_rise   <= w_rise;
      r_fall   <= w_fall;
      r_hold   <= w_hold_nxt;
      r_repeat <= w_repeat;
    end
  end

  assign o_btn_level   = r_level[3:0];
  assign o_btn_press   = r_rise[3:0];
  assign o_btn_release = r_fall[3:0];
  assign o_btn_repeat  = r_repeat;
  assign o_sw_level    = r_level[11:4];
  assign o_sw_change   = r_rise[11:4] | r_fall[11:4];
  assign o_tick        = w_tick;

endmodule

// File: tb/tb_button_scan.sv
// tb/tb_button_scan.sv - scoreboard bench for button_scan with a 16-clock tick
module tb_button_scan;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn_in = 4'h0;
  logic [7:0] sw_in = 8'hA5;
  logic [3:0] btn_level, btn_press, btn_release, btn_repeat;
  logic [7:0] sw_level, sw_change;
  logic       tick;

  button_scan #(
    .PRESCALE_BITS(4), .STABLE_SAMPLES(3), .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_btn_in(btn_in), .i_sw_in(sw_in),
    .o_btn_level(btn_level), .o_btn_press(btn_press), .o_btn_release(btn_release),
    .o_btn_repeat(btn_repeat), .o_sw_level(sw_level), .o_sw_change(sw_change),
    .o_tick(tick)
  );

  always #5 clk = ~clk;

  // Clocks since the last reset edge; the prescaler equals cyc mod 16.
  int cyc;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    int         cyc;
    logic [3:0] press, rel, rep, blvl;
    logic [7:0] chg, slvl;
  } ev_t;

  ev_t q[$];
  ev_t m_e;
  int  n_vec = 0;
  int  n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [3:0] p, input logic [3:0] r, input logic [3:0] rp,
                      input logic [3:0] bl, input logic [7:0] ch, input logic [7:0] sl);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.rep = rp; e.blvl = bl; e.chg = ch; e.slvl = sl;
    q.push_back(e);
  endtask

  // Repeats for a press visible at p fall on p+64, p+96, ...; keep those in [lo, hi).
  task automatic push_reps(input int p, input int lo, input int hi, input logic [3:0] m,
                           input logic [7:0] sl);
    for (int t = p + 64; t < hi; t += 32)
      if (t >= lo) push(t, 4'h0, 4'h0, m, m, 8'h00, sl);
  endtask

  // Input driven after edge c: seen from edge c+3, flips on the third tick edge from there.
  function automatic int flip_at(input int c);
    return 16 * ((c + 18) / 16 + 2);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 3000) begin
      step();
      n++;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d events pending, expected 0", q.size());
      q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (((btn_press | btn_release | btn_repeat) != 4'h0) || (sw_change != 8'h00))) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_event: cyc %0d press %b release %b repeat %b sw_change %h, expected none",
                 cyc, btn_press, btn_release, btn_repeat, sw_change);
      end else begin
        m_e = q.pop_front();
        chk("ev_cycle", 64'(cyc), 64'(m_e.cyc));
        chk("ev_press", 64'(btn_press), 64'(m_e.press));
        chk("ev_release", 64'(btn_release), 64'(m_e.rel));
        chk("ev_repeat", 64'(btn_repeat), 64'(m_e.rep));
        chk("ev_sw_change", 64'(sw_change), 64'(m_e.chg));
        chk("ev_btn_level", 64'(btn_level), 64'(m_e.blvl));
        chk("ev_sw_level", 64'(sw_level), 64'(m_e.slvl));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, p, r, last;

    // Reset with switches at A5
    repeat (3) step();
    chk("reset_outputs", 64'({btn_level, btn_press, btn_release, btn_repeat, sw_level, sw_change, tick}), 64'd0);
    push(48, 4'h0, 4'h0, 4'h0, 4'h0, 8'hA5, 8'hA5);
    reset = 1'b0;
    drain();
    chk("btn_level_post_reset", 64'(btn_level), 64'd0);

    // Press and hold btn[2] for 200 clocks
    c = cyc;
    p = flip_at(c);
    r = flip_at(c + 200);
    push(p, 4'b0100, 4'h0, 4'h0, 4'b0100, 8'h00, 8'hA5);
    push_reps(p, 0, r, 4'b0100, 8'hA5);
    push(r, 4'h0, 4'b0100, 4'h0, 4'h0, 8'h00, 8'hA5);
    btn_in = 4'b0100;
    repeat (200) step();
    btn_in = 4'h0;
    drain();

    // Bounce on btn[0], aligned mid-period
    while (cyc % 16 != 8) step();
    btn_in = 4'b0001; repeat (32) step();
    btn_in = 4'b0000; repeat (16) step();
    btn_in = 4'b0001; repeat (32) step();
    btn_in = 4'b0000; repeat (64) step();
    chk("bounce_btn_level", 64'(btn_level), 64'd0);
    chk("bounce_queue", 64'(q.size()), 64'd0);

    // Switches back to zero, then everything high in one clock
    c = cyc;
    push(flip_at(c), 4'h0, 4'h0, 4'h0, 4'h0, 8'hA5, 8'h00);
    sw_in = 8'h00;
    drain();
    c = cyc;
    p = flip_at(c);
    push(p, 4'hF, 4'h0, 4'h0, 4'hF, 8'hFF, 8'hFF);
    btn_in = 4'hF;
    sw_in  = 8'hFF;
    drain();
    c = cyc;
    r = flip_at(c);
    push_reps(p, 0, r, 4'hF, 8'hFF);
    push(r, 4'h0, 4'hF, 4'h0, 4'h0, 8'h00, 8'hFF);
    btn_in = 4'h0;
    drain();

    // Reset while btn[1] is repeating
    c = cyc;
    p = flip_at(c);
    push(p, 4'b0010, 4'h0, 4'h0, 4'b0010, 8'h00, 8'hFF);
    push_reps(p, 0, p + 97, 4'b0010, 8'hFF);
    btn_in = 4'b0010;
    drain();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midreset_outputs", 64'({btn_level, btn_press, btn_release, btn_repeat, sw_level, sw_change, tick}), 64'd0);
    push(48, 4'b0010, 4'h0, 4'h0, 4'b0010, 8'hFF, 8'hFF);
    push_reps(48, 0, 145, 4'b0010, 8'hFF);
    drain();
    c = cyc;
    r = flip_at(c);
    push_reps(48, c, r, 4'b0010, 8'hFF);
    push(r, 4'h0, 4'b0010, 4'h0, 4'h0, 8'h00, 8'hFF);
    btn_in = 4'h0;
    drain();

    // 40 ticks: phase, period and width
    last = -1;
    for (int i = 0; i < 40; i++) begin
      int n;
      n = 0;
      @(negedge clk);
      while (!tick && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (!tick) begin
        n_vec++;
        n_err++;
        $display("FAIL tick_timeout: no tick within 40 clocks, expected one every 16");
        break;
      end
      chk("tick_phase", 64'(cyc % 16), 64'd15);
      if (last >= 0) chk("tick_period", 64'(cyc - last), 64'd16);
      last = cyc;
      @(negedge clk);
      chk("tick_width", 64'(tick), 64'd0);
    end

    repeat (5) step();
    chk("final_queue_empty", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
